uart_tx: RTL and testbench

Serial UART transmitter that sends one byte per request as an asynchronous 8N1 frame: start bit, 8 data bits LSB first, stop bit. It sits between a byte-producing host and the external TX pin. Baud timing is derived by integer division of the system clock. A `busy` flag tells the host when a new byte can be accepted.

---
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: one-byte-per-request asynchronous serial transmitter, 8N1 framing.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       transmit,
    output logic       tx,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_data;
    logic            r_tx;
    logic            r_busy;

    state_t          w_state_nx;
    logic [CW-1:0]   w_cnt_nx;
    logic [2:0]      w_idx_nx;
    logic [7:0]      w_data_nx;
    logic            w_tx_nx;
    logic            w_busy_nx;
    logic            w_bit_done;

    assign w_bit_done = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = w_bit_done ? '0 : r_cnt + CW'(1);
        w_idx_nx   = r_idx;
        w_data_nx  = r_data;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (transmit) begin
                    w_state_nx = S_START;
                    w_data_nx  = data_in;
                    w_idx_nx   = '0;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_nx = S_DATA;
                    w_idx_nx   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_idx_nx = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nx = S_PARITY;
`else
                        w_state_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) w_state_nx = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_done) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Line level is decoded from the next state so tx is a plain register.
        w_tx_nx = 1'b1;
        case (w_state_nx)
            S_START:  w_tx_nx = 1'b0;
            S_DATA:   w_tx_nx = w_data_nx[w_idx_nx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nx = ^w_data_nx;
`endif
            default:  w_tx_nx = 1'b1;
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_data  <= w_data_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with a short bit period (8 clocks) to keep frames brief.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;
    localparam int CF = 100_000;
    localparam int BR = 12_000;
    localparam int C  = CF / BR;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       transmit = 1'b0;
    logic       tx;
    logic       busy;

    uart_tx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .transmit(transmit), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a frame is a list of line levels, each held C cycles from the accept edge.
    int          t = 0;
    bit          m_active = 1'b0;
    int          m_e = 0;
    logic [10:0] m_frame = '0;

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        bit q[$];
        logic [10:0] f;
        f = '0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        q.push_back(^d);
`endif
        q.push_back(1'b1);
        for (int k = 0; k < NB; k++) f[NB-1-k] = q[k];
        return f;
    endfunction

    task automatic check(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at cycle %0d", nm, act, exp, t);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        if (!rst_n) m_active = 1'b0;
        else if (m_active) begin
            if (t - m_e >= NB * C) m_active = 1'b0;
        end else if (transmit) begin
            m_active = 1'b1;
            m_e      = t;
            m_frame  = frame_of(data_in);
        end
        #1;
        check("model_busy", busy, m_active);
        check("model_tx", tx, m_active ? m_frame[NB-1-(t-m_e)/C] : 1'b1);
    endtask

    // Pulse a request, then check every bit centre against fr and the busy length.
    task automatic send_frame(input logic [7:0] d, input logic [10:0] fr, input bit poke);
        int te;
        data_in  = d;
        transmit = 1'b1;
        tick();
        transmit = 1'b0;
        data_in  = ~d;
        te = t;
        check("accept_busy", busy, 1'b1);
        check("accept_tx", tx, 1'b0);
        for (int k = 0; k < NB; k++) begin
            while (t < te + k * C + C / 2) tick();
            if (poke && k == 4) begin
                data_in  = 8'hFF;
                transmit = 1'b1;
                tick();
                transmit = 1'b0;
            end
            check("frame_bit", tx, fr[NB-1-k]);
        end
        while (busy === 1'b1 && t < te + NB * C + 20) tick();
        check_int("busy_len", t - te, NB * C);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[5];

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h55, 11'b01010101001};
        vecs[1] = '{8'hA3, 11'b01100010101};
        vecs[2] = '{8'h00, 11'b00000000001};
        vecs[3] = '{8'hFF, 11'b01111111101};
        vecs[4] = '{8'h01, 11'b01000000011};
`else
        vecs[0] = '{8'h55, 11'b00101010101};
        vecs[1] = '{8'hA3, 11'b00110001011};
        vecs[2] = '{8'h00, 11'b00000000001};
        vecs[3] = '{8'hFF, 11'b00111111111};
        vecs[4] = '{8'h01, 11'b00100000001};
`endif

        // Reset held, then released with no request.
        repeat (10) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_tx", tx, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].frame, 1'b0);
            repeat (C + 3) tick();
        end

        // Request while busy is dropped; no follow-on frame.
        send_frame(8'h55, vecs[0].frame, 1'b1);
        repeat (2 * C) tick();
        check("no_second_frame", busy, 1'b0);

        // Held request: request at the final frame edge is ignored, taken one edge later.
        begin
            int te;
            data_in  = 8'h3C;
            transmit = 1'b1;
            tick();
            te = t;
            while (t < te + NB * C) tick();
            check("b2b_gap_busy", busy, 1'b0);
            check("b2b_gap_tx", tx, 1'b1);
            tick();
            check("b2b_next_busy", busy, 1'b1);
            check("b2b_next_tx", tx, 1'b0);
            transmit = 1'b0;
            while (busy === 1'b1 && t < te + 2 * NB * C + 20) tick();
            check_int("b2b_second_len", t - te, 2 * NB * C + 1);
        end

        // Reset during data bit 3, then a clean frame.
        begin
            int te;
            data_in  = 8'hA3;
            transmit = 1'b1;
            tick();
            transmit = 1'b0;
            te = t;
            while (t < te + 4 * C + 2) tick();
            rst_n = 1'b0;
            tick();
            check("midrst_tx", tx, 1'b1);
            check("midrst_busy", busy, 1'b0);
            rst_n = 1'b1;
            tick();
            send_frame(8'hA3, vecs[1].frame, 1'b0);
        end

        // Reset and request together: reset wins.
        rst_n    = 1'b0;
        transmit = 1'b1;
        tick();
        check("rst_vs_req_busy", busy, 1'b0);
        rst_n    = 1'b1;
        transmit = 1'b0;
        tick();
        check("rst_vs_req_idle", busy, 1'b0);

        // Random requests, data churn and occasional resets against the model.
        for (int n = 0; n < 4000; n++) begin
            transmit = ($urandom_range(0, 15) == 0);
            data_in  = 8'($urandom);
            rst_n    = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
